// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, word geometry and the byte-masked merge used on stores.
package data_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Replace only the bytes whose enable bit is set; other bytes keep the old word.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array with byte-enabled synchronous write and registered read.
// Contents are never cleared by reset.
module mem_word_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // The read register only moves on a load access, so it holds steady through a stalled response.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= byte_merge(mem[addr], wdata, be);
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core's data-memory port: one request in flight, a programmable
// number of wait states, then a load/store response held until the core takes it.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              cap_write;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;
  logic              rsp_load;

  logic              accept;
  logic              access_en;
  logic              acc_write;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accepting edge, so it must use the live inputs.
  always_comb begin
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[WORD_W-1:AW+2] != '0);
  assign access_en = !rst && ((accept && (LATENCY == 0)) || (state == WAIT && wait_cnt == 4'd0));
  assign mem_we    = access_en && acc_write && !acc_err;
  assign mem_re    = access_en && !acc_write && !acc_err;

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_load ? mem_rdata : '0;

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (acc_addr[AW+1:2]),
    .wdata(acc_wdata),
    .be   (acc_be),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            if (LATENCY == 0) begin
              state    <= RESP;
              rsp_err  <= acc_err;
              rsp_load <= !acc_write && !acc_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state    <= RESP;
            rsp_err  <= acc_err;
            rsp_load <= !acc_write && !acc_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state    <= IDLE;
            rsp_err  <= 1'b0;
            rsp_load <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a LATENCY=2 instance for loads/stores, errors, backpressure and reset,
// plus a LATENCY=0 instance for back-to-back timing.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; lat counts negedges from the accepting edge to rsp_valid.
  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, output logic [31:0] rdata,
                                output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        seen;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("rst_z_req_ready", 32'(z_req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Zero wait states: store then load back to back, accepted two cycles apart.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8;
    z_req_wdata = 32'hCAFEF00D; z_req_be = 4'hF;
    @(negedge clk);
    check_output("z_store_rsp_valid", 32'(z_rsp_valid), 32'd1);
    check_output("z_store_req_ready", 32'(z_req_ready), 32'd0);
    check_output("z_store_err", 32'(z_rsp_err), 32'd0);
    z_req_write = 1'b0; z_req_wdata = 32'h0;
    @(negedge clk);
    check_output("z_gap_rsp_valid", 32'(z_rsp_valid), 32'd0);
    check_output("z_gap_req_ready", 32'(z_req_ready), 32'd1);
    @(negedge clk);
    z_req_valid = 1'b0;
    check_output("z_load_rsp_valid", 32'(z_rsp_valid), 32'd1);
    check_output("z_load_rdata", z_rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    check_output("z_done_rsp_valid", 32'(z_rsp_valid), 32'd0);

    // Basic store/load with latency measurement.
    apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check_output("st10_err", 32'(er), 32'd0);
    check_output("st10_rdata", rd, 32'h0);
    check_output("st10_lat", 32'(lat), 32'd3);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_output("ld10_rdata", rd, 32'hDEADBEEF);
    check_output("ld10_err", 32'(er), 32'd0);
    check_output("ld10_lat", 32'(lat), 32'd3);

    // Partial and empty byte enables.
    apply_stimulus(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    apply_stimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    check_output("st20_be_err", 32'(er), 32'd0);
    apply_stimulus(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check_output("ld20_merged", rd, 32'h11BB33DD);
    apply_stimulus(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    check_output("st10_be0_err", 32'(er), 32'd0);
    check_output("st10_be0_lat", 32'(lat), 32'd3);
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_output("ld10_after_be0", rd, 32'hDEADBEEF);

    // Top word is in range; misaligned and out-of-range accesses error out.
    apply_stimulus(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, rd, er, lat);
    check_output("stFFC_err", 32'(er), 32'd0);
    apply_stimulus(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    check_output("ldFFC_rdata", rd, 32'h0BADF00D);
    apply_stimulus(1'b1, 32'h0, 32'h55667788, 4'hF, rd, er, lat);
    apply_stimulus(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    check_output("ld13_err", 32'(er), 32'd1);
    check_output("ld13_rdata", rd, 32'h0);
    apply_stimulus(1'b1, 32'h1000, 32'h99999999, 4'hF, rd, er, lat);
    check_output("st1000_err", 32'(er), 32'd1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check_output("ld0_unchanged", rd, 32'h55667788);
    check_output("ld0_err", 32'(er), 32'd0);
    apply_stimulus(1'b1, 32'h40, 32'h0, 4'hF, rd, er, lat);

    // Backpressure: hold the response five cycles while the next request waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'h0;
    @(negedge clk);
    req_addr = 32'h20;
    n = 1;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_output("bp_lat", 32'(n), 32'd3);
    for (int k = 0; k < 5; k++) begin
      check_output("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check_output("bp_err", 32'(rsp_err), 32'd0);
      check_output("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_output("bp_after_hs_req_ready", 32'(req_ready), 32'd1);
    check_output("bp_after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_output("bp_next_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_output("bp_next_rdata", rsp_rdata, 32'h11BB33DD);

    // Reset while a store sits in WAIT: it must never be written or answered.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_be = 4'hF;
    @(negedge clk);
    check_output("rw_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("rw_req_ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_output("rw_rsp_valid_in_rst", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check_output("rw_req_ready_after_rst", 32'(req_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check_output("rw_no_rsp", 32'(seen), 32'd0);
    apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    check_output("rw_ld40", rd, 32'h0);
    check_output("rw_ld40_err", 32'(er), 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the core's data-memory port: accepts word load/store requests from the MIPS core over a valid/ready request channel, services them from an internal word array after a configurable number of wait states, and returns read data or a write acknowledgement on a valid/ready response channel. It sits between the core's load/store path and data storage. It replaces the core's fixed-timing RAM so that the core can be exercised against non-zero memory latency.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, ≥ 4
- LATENCY, 2, wait-state cycles between request acceptance and data access; 0–15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; bit i covers wdata[8i+7:8i]; ignored for loads
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned or out of range

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, capture write, addr, wdata, be. If LATENCY = 0, go to RESP; else load counter with LATENCY−1 and go to WAIT.
- WAIT: req_ready = 0. Counter decrements each cycle. On the cycle the counter equals 0, go to RESP.
- Access: performed on the edge that enters RESP.
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store: write only the enabled bytes. be = 0000 is a legal no-op store that is still acknowledged.
  - Load: rsp_rdata is latched from the array.
- Error: addr[1:0] ≠ 0, or addr ≥ 4·DEPTH_WORDS, sets rsp_err = 1 and rsp_rdata = 0. No array write occurs.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err hold stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Request inputs are sampled only at the accepting edge. Changes after that edge are ignored.
- Reset values (outputs registered or decoded from registered state):
  - state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 while rst = 1.
  - Array contents are not cleared.
- Reset mid-operation (WAIT or RESP):
  - The pending request is discarded.
  - A store still in WAIT is never written.
  - A store already committed on RESP entry is kept.

## Timing
- Accepting edge = E0. rsp_valid is first high in the cycle after edge E0+LATENCY (LATENCY = 0 → cycle immediately after E0).
- req_ready returns high in the cycle after the response handshake edge.
- Minimum spacing between accepted requests: LATENCY+2 cycles.
- Loads observe every store whose response was issued earlier. There is no read-during-write hazard, because only one request is in flight.
- rsp_ready held low: stall indefinitely in RESP with outputs frozen.
- rsp_ready high on entry to RESP: handshake completes in the first RESP cycle.

## Structure
- Package data_mem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - WORD_W = 32, BE_W = 4
  - helper function for the byte-masked merge
- Sub-module mem_word_array:
  - single-port, DEPTH_WORDS × 32
  - synchronous byte-enabled write
  - registered read, clocked by clk
- Top holds the FSM, the wait counter, the request capture registers and the range/alignment check.

## Test plan
- LATENCY = 2: store 0xDEADBEEF at 0x10 with be = 1111, then load 0x10 → store acked with rsp_err = 0; load rsp_rdata = 0xDEADBEEF; each rsp_valid rises 3 cycles after its acceptance edge.
- Byte enables: word 0x20 holds 0x11223344; store 0xAABBCCDD with be = 0101; load → 0x11BB33DD.
- Errors: load from 0x13 → rsp_err = 1, rdata = 0. Store to 0x1000 with DEPTH_WORDS = 1024 → rsp_err = 1, and a later load of 0x0 is unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid, rdata and err stay stable; req_ready stays 0 with req_valid high; the new request is accepted only in the cycle after the handshake.
- LATENCY = 0: back-to-back requests → rsp_valid in the cycle after each acceptance; accepted requests spaced 2 cycles apart.
- Reset in WAIT during a store to 0x40 (old value 0x0) → rsp_valid never rises; a later load of 0x40 returns 0x0; req_ready = 0 during rst and 1 in the first cycle after it.
